// File: rtl/tape_recorder.sv
// MIC capture: samples the ULA MIC level on prescaled ticks, run-length encodes the
// time between level changes into CSW-style pulse bytes and streams them into SDRAM.
module tape_recorder #(
  parameter int          DIV       = 79,
  parameter int          FIFO_AW   = 4,
  parameter logic [24:0] BASE_ADDR = 25'h0400000,
  parameter logic [24:0] MAX_LEN   = 25'h0100000
) (
  input  logic        clk_cpu,
  input  logic        nRESET,
  input  logic        enable,
  input  logic        mic_in,
  output logic        wr_req,
  output logic [24:0] wr_addr,
  output logic [7:0]  wr_data,
  input  logic        wr_ack,
  output logic [24:0] rec_len,
  output logic        busy,
  output logic        overflow,
  output logic        full
);

  localparam int PW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_RUN, S_EMIT_LONG, S_FLUSH, S_DONE} state_t;

  logic [PW-1:0]    presc_reg;
  logic             tick, edge_det;
  logic             mic_s1_reg, mic_s2_reg, lvl_reg;
  state_t           state_reg, state_next, ret_reg, ret_next, base_next;
  logic [31:0]      run_reg, run_next, run_inc, long_reg, long_next;
  logic [2:0]       idx_reg, idx_next;
  logic             emit_req, push, arm, ovf_set;
  logic [7:0]       push_data;
  logic [7:0]       mem [DEPTH];
  logic [FIFO_AW-1:0] wp_reg, rp_reg;
  logic [FIFO_AW:0] count_reg;
  logic             pop, start_wr, space_short, space_long;
  logic [24:0]      ptr_reg;

  assign tick     = (presc_reg == PW'(DIV - 1));
  assign edge_det = tick && (mic_s2_reg != lvl_reg);
  assign run_inc  = (run_reg == 32'hFFFF_FFFF) ? run_reg : run_reg + 32'd1;

  always_ff @(posedge clk_cpu or negedge nRESET) begin
    if (!nRESET) begin
      presc_reg  <= '0;
      mic_s1_reg <= 1'b0;
      mic_s2_reg <= 1'b0;
      lvl_reg    <= 1'b0;
    end else begin
      presc_reg  <= tick ? '0 : presc_reg + 1'b1;
      mic_s1_reg <= mic_in;
      mic_s2_reg <= mic_s1_reg;
      if (tick) lvl_reg <= mic_s2_reg;
    end
  end

  // Space is judged on the registered count, so a long record's 5 slots are reserved up front.
  assign space_short = (count_reg != (FIFO_AW+1)'(DEPTH));
  assign space_long  = (32'(count_reg) + 32'd5) <= 32'(DEPTH);

  always_ff @(posedge clk_cpu or negedge nRESET) begin
    if (!nRESET) begin
      state_reg <= S_IDLE;
      ret_reg   <= S_IDLE;
      run_reg   <= '0;
      long_reg  <= '0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ret_reg   <= ret_next;
      run_reg   <= run_next;
      long_reg  <= long_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    base_next  = state_reg;
    ret_next   = ret_reg;
    run_next   = run_reg;
    long_next  = long_reg;
    idx_next   = idx_reg;
    emit_req   = 1'b0;
    push       = 1'b0;
    push_data  = 8'h00;
    arm        = 1'b0;
    ovf_set    = 1'b0;
    case (state_reg)
      S_IDLE: if (enable) begin
        arm       = 1'b1;
        run_next  = '0;
        base_next = S_ARMED;
      end
      S_ARMED: begin
        if (!enable) base_next = S_DONE;
        else if (edge_det) begin
          run_next  = 32'd1;
          base_next = S_RUN;
        end
      end
      S_RUN: begin
        if (edge_det) begin
          emit_req = 1'b1;
          run_next = 32'd1;
        end else if (tick) begin
          run_next = run_inc;
        end
        base_next = enable ? S_RUN : S_FLUSH;
      end
      S_EMIT_LONG: begin
        push = 1'b1;
        case (idx_reg)
          3'd0:    push_data = 8'h00;
          3'd1:    push_data = long_reg[7:0];
          3'd2:    push_data = long_reg[15:8];
          3'd3:    push_data = long_reg[23:16];
          default: push_data = long_reg[31:24];
        endcase
        if (tick) run_next = run_inc;
        if (idx_reg == 3'd4) base_next = (ret_reg == S_RUN && !enable) ? S_FLUSH : ret_reg;
        else idx_next = idx_reg + 3'd1;
      end
      S_FLUSH: begin
        emit_req  = (run_reg != '0);
        run_next  = '0;
        base_next = S_DONE;
      end
      S_DONE: if (!enable) base_next = S_IDLE;
      default: base_next = S_IDLE;
    endcase
    state_next = base_next;
    // A pulse is either pushed whole or dropped whole; never split across a full FIFO.
    if (emit_req) begin
      if (run_reg <= 32'd255) begin
        if (space_short) begin
          push      = 1'b1;
          push_data = run_reg[7:0];
        end else begin
          ovf_set = 1'b1;
        end
      end else if (space_long) begin
        long_next  = run_reg;
        idx_next   = '0;
        ret_next   = base_next;
        state_next = S_EMIT_LONG;
      end else begin
        ovf_set = 1'b1;
      end
    end
  end

  assign start_wr = !wr_req && (count_reg != '0) && !full;
  assign pop      = (count_reg != '0) && (full || !wr_req);

  always_ff @(posedge clk_cpu) begin
    if (push) mem[wp_reg] <= push_data;
  end

  always_ff @(posedge clk_cpu or negedge nRESET) begin
    if (!nRESET) begin
      wp_reg    <= '0;
      rp_reg    <= '0;
      count_reg <= '0;
    end else begin
      if (push) wp_reg <= wp_reg + 1'b1;
      if (pop)  rp_reg <= rp_reg + 1'b1;
      if (push && !pop)      count_reg <= count_reg + 1'b1;
      else if (!push && pop) count_reg <= count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk_cpu or negedge nRESET) begin
    if (!nRESET) begin
      wr_req   <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      rec_len  <= '0;
      overflow <= 1'b0;
      full     <= 1'b0;
      ptr_reg  <= '0;
    end else begin
      if (wr_req && wr_ack) begin
        wr_req  <= 1'b0;
        ptr_reg <= ptr_reg + 25'd1;
        rec_len <= rec_len + 25'd1;
        if (rec_len + 25'd1 == MAX_LEN) full <= 1'b1;
      end else if (start_wr) begin
        wr_req  <= 1'b1;
        wr_addr <= ptr_reg;
        wr_data <= mem[rp_reg];
      end
      if (ovf_set) overflow <= 1'b1;
      if (arm) begin
        rec_len  <= '0;
        overflow <= 1'b0;
        full     <= 1'b0;
        ptr_reg  <= BASE_ADDR;
      end
    end
  end

  assign busy = !(state_reg == S_IDLE || state_reg == S_DONE) || (count_reg != '0) || wr_req;

endmodule

// File: tb/tb_tape_recorder.sv
// Randomised bench for tape_recorder: a pulse-level model predicts the SDRAM byte stream,
// a monitor checks every write request against it.
module tb_tape_recorder;
  localparam int          DIV   = 8;
  localparam int          FAW   = 4;
  localparam int          DEPTH = 1 << FAW;
  localparam logic [24:0] BASE  = 25'h0400000;
  localparam int          MAXL  = 40;

  logic clk_cpu = 1'b0;
  logic nRESET = 1'b0, enable = 1'b0, mic_in = 1'b0, wr_ack = 1'b0;
  logic wr_req, busy, overflow, full;
  logic [24:0] wr_addr, rec_len;
  logic [7:0]  wr_data;

  tape_recorder #(.DIV(DIV), .FIFO_AW(FAW), .BASE_ADDR(BASE), .MAX_LEN(25'(MAXL))) dut (
    .clk_cpu(clk_cpu), .nRESET(nRESET), .enable(enable), .mic_in(mic_in),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rec_len(rec_len), .busy(busy), .overflow(overflow), .full(full)
  );

  always #5 clk_cpu = ~clk_cpu;

  typedef struct packed {logic [24:0] a; logic [7:0] d;} wr_t;
  wr_t exp_q[$];
  int  ivals[$];
  int  total = 0, bad = 0;
  int  cyc;
  int  sess_cnt = 0, held = 0;
  bit  exp_ovf = 0, stall = 0, stall_model = 0;

  always @(posedge clk_cpu or negedge nRESET)
    if (!nRESET) cyc <= 0; else cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Memory side: random ack latency, occasional stray ack while idle, optional stall.
  int dly = 0;
  always @(negedge clk_cpu) begin
    if (!nRESET) wr_ack = 1'b0;
    else if (wr_ack) wr_ack = 1'b0;
    else if (wr_req && !stall) begin
      if (dly == 0) begin
        wr_ack = 1'b1;
        dly = $urandom_range(0, 3);
      end else dly--;
    end else if (!wr_req && !stall && $urandom_range(0, 15) == 0) wr_ack = 1'b1;
  end

  logic        prev_req = 1'b0;
  logic [24:0] prev_a = '0;
  logic [7:0]  prev_d = '0;
  always @(negedge clk_cpu) begin
    wr_t e;
    if (wr_req && !prev_req) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_write: got addr=%h data=%h required no write", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        $display("write addr=%h data=%h", wr_addr, wr_data);
        check("wr_addr", 32'(wr_addr), 32'(e.a));
        check("wr_data", 32'(wr_data), 32'(e.d));
      end
    end else if (wr_req && prev_req) begin
      check("hold_stable", {wr_addr, wr_data}, {prev_a, prev_d});
    end
    prev_req = wr_req;
    prev_a   = wr_addr;
    prev_d   = wr_data;
  end

  task automatic to_tick();
    forever begin
      @(negedge clk_cpu);
      if (cyc % DIV == 0) break;
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) to_tick();
  endtask

  // Same as ticks() but may insert a 2-cycle MIC glitch between ticks.
  task automatic ticks_g(input int n);
    repeat (n) begin
      if ($urandom_range(0, 1) == 0) begin
        mic_in = ~mic_in;
        @(negedge clk_cpu);
        @(negedge clk_cpu);
        mic_in = ~mic_in;
      end
      to_tick();
    end
  endtask

  // Encodes one pulse of r ticks and queues the bytes that must reach memory.
  task automatic model_emit(input int r);
    logic [7:0]  b[$];
    logic [31:0] v;
    wr_t         e;
    int          used;
    v = 32'(r);
    if (r <= 255) b.push_back(v[7:0]);
    else begin
      b.push_back(8'h00);
      b.push_back(v[7:0]);
      b.push_back(v[15:8]);
      b.push_back(v[23:16]);
      b.push_back(v[31:24]);
    end
    if (stall_model) begin
      used = (held > 0) ? held - 1 : 0;
      if (DEPTH - used < b.size()) begin
        exp_ovf = 1'b1;
        return;
      end
      held += b.size();
    end
    foreach (b[i]) begin
      if (sess_cnt < MAXL) begin
        e.a = BASE + 25'(sess_cnt);
        e.d = b[i];
        exp_q.push_back(e);
      end
      sess_cnt++;
    end
  endtask

  task automatic session(input int lead, input int w);
    sess_cnt = 0; held = 0; exp_ovf = 1'b0;
    to_tick();
    enable = 1'b1;
    ticks_g(lead);
    mic_in = ~mic_in;
    foreach (ivals[i]) begin
      ticks_g(ivals[i]);
      mic_in = ~mic_in;
      model_emit(ivals[i]);
    end
    ticks_g(w);
    enable = 1'b0;
    model_emit(w);
  endtask

  task automatic finish_session();
    int n;
    int exp_len;
    n = 0;
    while (busy && n < 5000) begin
      @(negedge clk_cpu);
      n++;
    end
    repeat (10) @(negedge clk_cpu);
    exp_len = (sess_cnt < MAXL) ? sess_cnt : MAXL;
    check("busy_idle", 32'(busy), 32'd0);
    check("rec_len", 32'(rec_len), 32'(exp_len));
    check("overflow", 32'(overflow), 32'(exp_ovf));
    check("full", 32'(full), 32'(sess_cnt >= MAXL));
    check("writes_pending", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_req"}, 32'(wr_req), 32'd0);
    check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    check({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    check({tag, "_rec_len"}, 32'(rec_len), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
    check({tag, "_full"}, 32'(full), 32'd0);
  endtask

  task automatic random_session();
    int  n;
    int  k;
    bit  had_long;
    had_long = 1'b0;
    ivals.delete();
    n = $urandom_range(2, 6);
    repeat (n) begin
      k = $urandom_range(0, 9);
      if (k == 0 && !had_long) begin
        ivals.push_back($urandom_range(256, 300));
        had_long = 1'b1;
      end else if (k == 1) ivals.push_back(255);
      else if (k == 2) ivals.push_back(1);
      else ivals.push_back($urandom_range(2, 40));
    end
    session($urandom_range(0, 5), $urandom_range(1, 20));
    finish_session();
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk_cpu);
    check_all_zero("reset");
    nRESET = 1'b1;

    // Three 10-tick pulses plus a 4-tick flush.
    ivals = '{10, 10, 10};
    session(2, 4);
    finish_session();

    // 300-tick pulse takes the long form.
    ivals = '{300};
    session(1, 5);
    finish_session();

    // Writes stalled: FIFO fills, a long pulse with 4 free slots and the excess shorts are dropped.
    stall = 1'b1; stall_model = 1'b1;
    ivals.delete();
    repeat (13) ivals.push_back(2);
    ivals.push_back(300);
    repeat (5) ivals.push_back(2);
    session(1, 3);
    repeat (40) @(negedge clk_cpu);
    check("overflow_sticky", 32'(overflow), 32'd1);
    check("req_held", 32'(wr_req), 32'd1);
    stall = 1'b0;
    finish_session();
    stall_model = 1'b0;

    // More pulses than MAX_LEN bytes.
    ivals.delete();
    repeat (45) ivals.push_back($urandom_range(1, 3));
    session(0, 2);
    finish_session();

    repeat (4) random_session();

    // Reset while a write is pending and a long record is being pushed.
    stall = 1'b1;
    sess_cnt = 0; held = 0; exp_ovf = 1'b0;
    to_tick();
    enable = 1'b1;
    ticks(1);
    mic_in = ~mic_in;
    ticks(3);
    mic_in = ~mic_in;
    model_emit(3);
    ticks(300);
    mic_in = ~mic_in;
    to_tick();
    @(negedge clk_cpu);
    check("req_before_reset", 32'(wr_req), 32'd1);
    nRESET = 1'b0;
    #1;
    check_all_zero("midreset");
    exp_q.delete();
    stall = 1'b0;
    enable = 1'b0;
    mic_in = 1'b0;
    repeat (3) @(negedge clk_cpu);
    nRESET = 1'b1;
    random_session();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
